// File: rtl/clk_div_frac_pkg.sv
// Shared types and defaults for the fractional clock-enable generator.
// Optional ce counter / busy flag is enabled by CLK_DIV_FRAC_CE_CNT_EN.
package clk_div_frac_pkg;

   localparam int W_DEF       = 8;
   localparam int DEF_NUM_DEF = 2;
   localparam int DEF_DEN_DEF = 3;
   localparam int CFG_MAX_W   = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PEND = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CFG_OK    = 2'd0,
      CFG_CLAMP = 2'd1,
      CFG_DROP  = 2'd2
   } cfg_res_t;

   // A zero denominator is unusable; an oversized numerator saturates to the denominator.
   function automatic cfg_res_t cfg_check(input logic [CFG_MAX_W-1:0] num,
                                          input logic [CFG_MAX_W-1:0] den);
      cfg_res_t res;
      if (den == '0)
         res = CFG_DROP;
      else if (num > den)
         res = CFG_CLAMP;
      else
         res = CFG_OK;
      return res;
   endfunction

endpackage

// File: rtl/clk_div_frac_acc.sv
// Phase accumulator for the NUM/DEN enable pattern; o_wrap marks a cycle
// where the accumulated phase crosses the denominator.
module clk_div_frac_acc
#(
   parameter int W = 8
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_num,
   input  logic [W-1:0] i_den,
   input  logic         i_clear,
   input  logic         i_step,
   output logic         o_wrap,
   output logic [W-1:0] o_acc
);

   logic [W-1:0] r_acc;
   logic [W:0]   w_sum;
   logic [W-1:0] w_diff;

   // One extra bit so acc + num never overflows before the compare.
   assign w_sum  = {1'b0, r_acc} + {1'b0, i_num};
   assign w_diff = w_sum[W-1:0] - i_den;
   assign o_wrap = i_step && (w_sum >= {1'b0, i_den});
   assign o_acc  = r_acc;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_acc <= '0;
      else if (i_clear)
         r_acc <= '0;
      else if (i_step)
         r_acc <= o_wrap ? w_diff : w_sum[W-1:0];
   end

endmodule

// File: rtl/clk_div_frac_ce.sv
// Fractional clock-enable generator: ce_out fires NUM times per DEN cycles.
// Define CLK_DIV_FRAC_CE_CNT_EN to add the ce_cnt pulse counter and ratio_busy.
module clk_div_frac_ce
   import clk_div_frac_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int DEF_NUM = DEF_NUM_DEF,
   parameter int DEF_DEN = DEF_DEN_DEF
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_num,
   input  logic [W-1:0] cfg_den,
   output logic         cfg_err,
   output logic         ce_out,
   output logic         tgl_out
`ifdef CLK_DIV_FRAC_CE_CNT_EN
   ,
   output logic [15:0]  ce_cnt,
   output logic         ratio_busy
`endif
);

   state_t       r_state;
   logic [W-1:0] r_num;
   logic [W-1:0] r_den;
   logic [W-1:0] r_sh_num;
   logic [W-1:0] r_sh_den;
   logic         r_ce;
   logic         r_tgl;
   logic         r_cfg_ready;
   logic         r_cfg_err;

   state_t       w_state_nxt;
   logic [W-1:0] w_num_nxt;
   logic [W-1:0] w_den_nxt;
   logic [W-1:0] w_sh_num_nxt;
   logic [W-1:0] w_sh_den_nxt;
   logic         w_ce_nxt;
   logic         w_tgl_nxt;
   logic         w_ready_nxt;
   logic         w_err_nxt;
   logic         w_apply;

   cfg_res_t     w_chk;
   logic         w_xfer;
   logic         w_xfer_ok;
   logic [W-1:0] w_cfg_num_eff;
   logic         w_step;
   logic         w_acc_clear;
   logic         w_wrap;
   logic [W-1:0] w_acc;

   assign w_chk         = cfg_check(CFG_MAX_W'(cfg_num), CFG_MAX_W'(cfg_den));
   assign w_xfer        = cfg_valid && r_cfg_ready;
   assign w_xfer_ok     = w_xfer && (w_chk != CFG_DROP);
   assign w_cfg_num_eff = (w_chk == CFG_CLAMP) ? cfg_den : cfg_num;

   // The accumulator only advances while running; leaving RUN/PEND or
   // applying a new ratio restarts the phase from zero.
   assign w_step      = (r_state != S_IDLE) && enable;
   assign w_acc_clear = !w_step || w_apply;

   clk_div_frac_acc #(.W(W)) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_num   (r_num),
      .i_den   (r_den),
      .i_clear (w_acc_clear),
      .i_step  (w_step),
      .o_wrap  (w_wrap),
      .o_acc   (w_acc)
   );

   // NOTE: every signal driven here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt  = r_state;
      w_num_nxt    = r_num;
      w_den_nxt    = r_den;
      w_sh_num_nxt = r_sh_num;
      w_sh_den_nxt = r_sh_den;
      w_ce_nxt     = 1'b0;
      w_tgl_nxt    = r_tgl;
      w_ready_nxt  = r_cfg_ready;
      w_err_nxt    = w_xfer && (w_chk != CFG_OK);
      w_apply      = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tgl_nxt = 1'b0;
            if (w_xfer_ok) begin
               w_num_nxt = w_cfg_num_eff;
               w_den_nxt = cfg_den;
            end
            if (enable)
               w_state_nxt = S_RUN;
         end

         S_RUN: begin
            if (!enable) begin
               w_state_nxt = S_IDLE;
               w_tgl_nxt   = 1'b0;
               if (w_xfer_ok) begin
                  w_num_nxt = w_cfg_num_eff;
                  w_den_nxt = cfg_den;
               end
            end else begin
               w_ce_nxt  = w_wrap;
               w_tgl_nxt = r_tgl ^ w_wrap;
               if (w_xfer_ok) begin
                  w_sh_num_nxt = w_cfg_num_eff;
                  w_sh_den_nxt = cfg_den;
                  w_state_nxt  = S_PEND;
                  w_ready_nxt  = 1'b0;
               end
            end
         end

         S_PEND: begin
            if (!enable) begin
               w_state_nxt = S_IDLE;
               w_tgl_nxt   = 1'b0;
               w_num_nxt   = r_sh_num;
               w_den_nxt   = r_sh_den;
               w_ready_nxt = 1'b1;
            end else begin
               w_ce_nxt  = w_wrap;
               w_tgl_nxt = r_tgl ^ w_wrap;
               // A zero numerator never wraps, so it must not block the swap.
               if (w_wrap || (r_num == '0)) begin
                  w_num_nxt   = r_sh_num;
                  w_den_nxt   = r_sh_den;
                  w_apply     = 1'b1;
                  w_state_nxt = S_RUN;
                  w_ready_nxt = 1'b1;
               end
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_num       <= W'(DEF_NUM);
         r_den       <= W'(DEF_DEN);
         r_sh_num    <= '0;
         r_sh_den    <= '0;
         r_ce        <= 1'b0;
         r_tgl       <= 1'b0;
         r_cfg_ready <= 1'b1;
         r_cfg_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_num       <= w_num_nxt;
         r_den       <= w_den_nxt;
         r_sh_num    <= w_sh_num_nxt;
         r_sh_den    <= w_sh_den_nxt;
         r_ce        <= w_ce_nxt;
         r_tgl       <= w_tgl_nxt;
         r_cfg_ready <= w_ready_nxt;
         r_cfg_err   <= w_err_nxt;
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign cfg_err   = r_cfg_err;
   assign ce_out    = r_ce;
   assign tgl_out   = r_tgl;

   // The phase always stays below the active denominator.
   a_acc_below_den: assert property (@(posedge clk) disable iff (!rst_n) w_acc < r_den);

`ifdef CLK_DIV_FRAC_CE_CNT_EN
   logic [15:0] r_ce_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ce_cnt <= '0;
      else if (!w_step)
         r_ce_cnt <= '0;
      else if (w_wrap)
         r_ce_cnt <= r_ce_cnt + 16'd1;
   end

   assign ce_cnt     = r_ce_cnt;
   assign ratio_busy = (r_state == S_PEND);
`endif

endmodule
